// File: rtl/wb_pkg.sv
// Shared constants and types for the writeback select stage.
package wb_pkg;

    // Conventional source slots on the writeback mux
    localparam int unsigned WB_SRC_ALU  = 0;
    localparam int unsigned WB_SRC_MEM  = 1;
    localparam int unsigned WB_SRC_JAL  = 2;
    localparam int unsigned WB_SRC_CMOV = 3;

    localparam int unsigned WB_DEF_WIDTH = 32;
    localparam int unsigned WB_DEF_REGW  = 5;

    typedef enum logic [0:0] {
        WB_IDLE,
        WB_WAIT
    } wb_state_e;

endpackage

// File: rtl/wb_src_select.sv
// Combinational NSRC:1 selector over a flattened source bus.
module wb_src_select #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NSRC  = 4,
    parameter int unsigned SELW  = 2
) (
    input  logic [SELW-1:0]       sel,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic [NSRC-1:0]       src_valid,
    output logic [WIDTH-1:0]      data,
    output logic                  valid,
    output logic                  illegal
);

    // Walk the legal indices; anything unmatched is an illegal selector
    always_comb begin
        data    = '0;
        valid   = 1'b0;
        illegal = 1'b1;
        for (int k = 0; k < NSRC; k++) begin
            if (sel == SELW'(k)) begin
                data    = src_data[k*WIDTH +: WIDTH];
                valid   = src_valid[k];
                illegal = 1'b0;
            end
        end
    end

endmodule

// File: rtl/wb_select_stage.sv
// Writeback select-and-register stage: picks a result source, waits for late
// sources with a bounded timeout, and registers the writeback for the RF port.
module wb_select_stage
    import wb_pkg::*;
#(
    parameter int unsigned WIDTH   = WB_DEF_WIDTH,
    parameter int unsigned NSRC    = 4,
    parameter int unsigned REGW    = WB_DEF_REGW,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned SELW    = $clog2(NSRC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SELW-1:0]       in_sel,
    input  logic [REGW-1:0]       in_rd,
    input  logic                  in_we,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic [NSRC-1:0]       src_valid,
    input  logic                  flush,
    input  logic                  err_clr,
    output logic                  stall,
    output logic                  wb_valid,
    output logic [WIDTH-1:0]      wb_data,
    output logic [REGW-1:0]       wb_rd,
    output logic                  wb_we,
    output logic                  err_sel,
    output logic                  err_timeout
);

    localparam int unsigned CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

    logic [WIDTH-1:0] sel_data;
    logic             sel_valid;
    logic             sel_illegal;

    wb_src_select #(
        .WIDTH (WIDTH),
        .NSRC  (NSRC),
        .SELW  (SELW)
    ) u_src_select (
        .sel       (in_sel),
        .src_data  (src_data),
        .src_valid (src_valid),
        .data      (sel_data),
        .valid     (sel_valid),
        .illegal   (sel_illegal)
    );

    wb_state_e        state_q, state_d;
    logic [CNTW-1:0]  wait_cnt_q, wait_cnt_d;
    logic             wb_valid_q, wb_valid_d;
    logic [WIDTH-1:0] wb_data_q, wb_data_d;
    logic [REGW-1:0]  wb_rd_q, wb_rd_d;
    logic             wb_we_q, wb_we_d;
    logic             err_sel_q, err_sel_d;
    logic             err_timeout_q, err_timeout_d;

    logic accept, timeout, illegal;

    // Next state: flush beats everything, then illegal sel, accept, timeout.
    // wait_cnt counts every waiting cycle, including the one that leaves IDLE,
    // so an instruction waits at most TIMEOUT cycles in total.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        accept     = 1'b0;
        timeout    = 1'b0;
        illegal    = 1'b0;
        if (flush || !in_valid) begin
            state_d    = WB_IDLE;
            wait_cnt_d = '0;
        end else if (sel_illegal) begin
            illegal    = 1'b1;
            state_d    = WB_IDLE;
            wait_cnt_d = '0;
        end else if (sel_valid) begin
            accept     = 1'b1;
            state_d    = WB_IDLE;
            wait_cnt_d = '0;
        end else if (state_q == WB_WAIT && wait_cnt_q == CNT_LAST) begin
            timeout    = 1'b1;
            state_d    = WB_IDLE;
            wait_cnt_d = '0;
        end else begin
            state_d    = WB_WAIT;
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    // Handshake outputs; an illegal selector retires at once, so it never stalls
    always_comb begin
        in_ready = accept | timeout | illegal;
        stall    = in_valid & ~flush & ~sel_illegal & ~sel_valid;
    end

    // Writeback register and sticky error next-state
    always_comb begin
        wb_valid_d    = accept | illegal;
        wb_data_d     = wb_data_q;
        wb_rd_d       = wb_rd_q;
        wb_we_d       = accept & in_we & (in_rd != '0);
        if (accept) begin
            wb_data_d = sel_data;
            wb_rd_d   = in_rd;
        end else if (illegal) begin
            wb_data_d = '0;
            wb_rd_d   = in_rd;
        end
        err_sel_d     = illegal | (err_sel_q & ~err_clr);
        err_timeout_d = timeout | (err_timeout_q & ~err_clr);
    end

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WB_IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Writeback and error flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q    <= 1'b0;
            wb_data_q     <= '0;
            wb_rd_q       <= '0;
            wb_we_q       <= 1'b0;
            err_sel_q     <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            wb_valid_q    <= wb_valid_d;
            wb_data_q     <= wb_data_d;
            wb_rd_q       <= wb_rd_d;
            wb_we_q       <= wb_we_d;
            err_sel_q     <= err_sel_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign wb_valid    = wb_valid_q;
    assign wb_data     = wb_data_q;
    assign wb_rd       = wb_rd_q;
    assign wb_we       = wb_we_q;
    assign err_sel     = err_sel_q;
    assign err_timeout = err_timeout_q;

endmodule
